// File: rtl/i2c_bus_arbiter_pkg.sv
// Purpose: shared FSM state type, byte-count limit and watchdog default for the I2C bus arbiter.
// Latency: none; declarations only.
// Backpressure: none; declarations only.
package i2c_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    XFER   = 3'd2,
    DRAIN  = 3'd3,
    FINISH = 3'd4
  } arb_state_e;

  localparam int MAX_NBYTES             = 4;
  localparam int DEFAULT_TIMEOUT_CYCLES = 500000;  // 10 ms at 50 MHz

  // Requesters may ask for 0 or more than MAX_NBYTES bytes; the master only
  // handles 1..MAX_NBYTES, so fold out-of-range counts into that window.
  function automatic logic [7:0] clamp_nbytes(input logic [7:0] n);
    if (n == 8'd0) begin
      return 8'd1;
    end else if (n > 8'(MAX_NBYTES)) begin
      return 8'(MAX_NBYTES);
    end else begin
      return n;
    end
  endfunction

endpackage

// File: rtl/i2c_bus_arbiter_rr_select.sv
// Purpose: round-robin pick of the first requester strictly after last_grant.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the pick.
// Ports: req (request levels), last_grant (index served last),
//        grant_nxt (one-hot pick), grant_idx (its index), any_req (some req high).
module rr_select #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant_nxt,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  int   idx;
  logic found;

  // Walk the ring starting one past the previous owner; the previous owner
  // itself is visited last, so a requester that stays high yields to others.
  always_comb begin
    grant_nxt = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found          = 1'b1;
        grant_nxt[idx] = 1'b1;
        grant_idx      = IDX_W'(idx);
      end
    end
    any_req = |req;
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Purpose: shares one i2c_master among NUM_REQ requesters with round-robin arbitration and a watchdog.
// Latency: grant 1 cycle after req in IDLE, m_ena 1 cycle after grant, done 1 cycle after master idle.
// Backpressure: requesters hold req until done; a busy master stalls the FSM up to TIMEOUT_CYCLES.
// Ports: req/req_* (per-requester transaction), grant/done/data_rd/error (per-transaction result),
//        m_* outputs drive the external i2c_master, m_* inputs return its status.
module i2c_bus_arbiter
  import i2c_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [7*NUM_REQ-1:0]    req_addr,
  input  logic [NUM_REQ-1:0]      req_rw,
  input  logic [32*NUM_REQ-1:0]   req_data_wr,
  input  logic [8*NUM_REQ-1:0]    req_nbytes,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      done,
  output logic [31:0]             data_rd,
  output logic                    error,
  output logic                    m_ena,
  output logic [6:0]              m_addr,
  output logic                    m_rw,
  output logic [31:0]             m_data_wr,
  output logic [7:0]              m_nbytes,
  input  logic                    m_busy,
  input  logic [7:0]              m_byte_counter,
  input  logic [31:0]             m_data_rd,
  input  logic                    m_ack_error
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_e         state_q;
  arb_state_e         state_d;
  logic [NUM_REQ-1:0] rr_grant;
  logic [IDX_W-1:0]   rr_idx;
  logic               rr_any;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   last_grant_q;
  logic [WD_W-1:0]    wdog_q;
  logic               wd_expire;
  logic               xfer_done;
  logic               drain_done;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .req        (req),
    .last_grant (last_grant_q),
    .grant_nxt  (rr_grant),
    .grant_idx  (rr_idx),
    .any_req    (rr_any)
  );

  // The watchdog counts XFER/DRAIN cycles; expiring on TIMEOUT_CYCLES-1 means
  // the transition happens on the edge where the count would reach the limit.
  assign wd_expire  = (wdog_q >= WD_W'(TIMEOUT_CYCLES - 1));
  assign xfer_done  = (m_byte_counter >= m_nbytes);
  assign drain_done = !m_busy && !m_ena;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    done    = '0;
    case (state_q)
      IDLE: begin
        if (rr_any) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = XFER;
      end
      XFER: begin
        if (wd_expire) begin
          state_d = FINISH;
        end else if (xfer_done) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (wd_expire || drain_done) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        done    = grant;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      grant        <= '0;
      owner_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      wdog_q       <= '0;
      data_rd      <= '0;
      error        <= 1'b0;
      m_ena        <= 1'b0;
      m_addr       <= '0;
      m_rw         <= 1'b0;
      m_data_wr    <= '0;
      m_nbytes     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rr_any) begin
            grant   <= rr_grant;
            owner_q <= rr_idx;
          end
        end
        LOAD: begin
          // Snapshot the owner's request so later req_* changes cannot
          // disturb a transaction already on the wire.
          m_addr    <= req_addr[int'(owner_q)*7 +: 7];
          m_rw      <= req_rw[owner_q];
          m_data_wr <= req_data_wr[int'(owner_q)*32 +: 32];
          m_nbytes  <= clamp_nbytes(req_nbytes[int'(owner_q)*8 +: 8]);
          m_ena     <= 1'b1;
          wdog_q    <= '0;
          error     <= m_ack_error;
        end
        XFER: begin
          wdog_q <= wdog_q + WD_W'(1);
          error  <= error | m_ack_error;
          if (wd_expire) begin
            m_ena <= 1'b0;
            error <= 1'b1;
          end else if (xfer_done) begin
            m_ena <= 1'b0;
          end
        end
        DRAIN: begin
          wdog_q <= wdog_q + WD_W'(1);
          error  <= error | m_ack_error;
          if (wd_expire) begin
            m_ena <= 1'b0;
            error <= 1'b1;
          end else if (drain_done && m_rw) begin
            data_rd <= m_data_rd;
          end
        end
        FINISH: begin
          last_grant_q <= owner_q;
          grant        <= '0;
        end
        default: begin
          grant <= '0;
          m_ena <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/i2c_bus_arbiter.md
I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requester ports, range 2..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 500000: watchdog limit in clock cycles, 10 ms at 50 MHz.
REQ-003 clock  input  1  system clock; all logic on its rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 req  input  NUM_REQ  per-requester transaction request level, held high until done.
REQ-006 req_addr  input  7*NUM_REQ  per-requester 7-bit device id.
REQ-007 req_rw  input  NUM_REQ  per-requester direction: 1 = read, 0 = write.
REQ-008 req_data_wr  input  32*NUM_REQ  per-requester write word.
REQ-009 req_nbytes  input  8*NUM_REQ  per-requester byte count, 1..4.
REQ-010 grant  output  NUM_REQ  one-hot owner of the bus; all zero when free.
REQ-011 done  output  NUM_REQ  one-cycle completion pulse to the owner.
REQ-012 data_rd  output  32  read word, valid in the done cycle and held until the next done.
REQ-013 error  output  1  ack_error or timeout for the finishing transaction; valid with done.
REQ-014 m_ena, m_addr[6:0], m_rw, m_data_wr[31:0], m_nbytes[7:0]  output  controls for i2c_master.
REQ-015 m_busy, m_byte_counter[7:0], m_data_rd[31:0], m_ack_error  input  status from i2c_master.

Function
REQ-016 The FSM SHALL use states IDLE, LOAD, XFER, DRAIN and FINISH.
REQ-017 IDLE, any req high: select the first requesting index after last_grant, modulo NUM_REQ (round-robin); set grant one-hot; go to LOAD.
REQ-018 The first selection after reset SHALL start search at index 0.
REQ-019 LOAD: latch the owner's addr, rw, data_wr and nbytes into m_* registers; set m_ena=1; go to XFER.
REQ-020 The m_* outputs SHALL be stable from LOAD until return to IDLE, independent of later req_* changes.
REQ-021 XFER: when m_byte_counter >= m_nbytes, clear m_ena and go to DRAIN.
REQ-022 DRAIN: when m_busy==0 and m_ena==0, capture m_data_rd into data_rd (read only) and go to FINISH.
REQ-023 A write transaction SHALL leave data_rd unchanged.
REQ-024 error SHALL be set if m_ack_error is seen high at any cycle from LOAD through DRAIN.
REQ-025 FINISH: pulse done[owner] for exactly one cycle, update last_grant, clear grant, go to IDLE.
REQ-026 The minimum re-arbitration gap SHALL be one IDLE cycle, so one requester cannot starve others.
REQ-027 A req deasserted while granted SHALL NOT abort; the transaction runs to FINISH and done still pulses.
REQ-028 A requester that keeps req high after done SHALL be re-served only after all other pending requesters.
REQ-029 A watchdog counter SHALL clear in LOAD and increment in XFER/DRAIN.
REQ-030 On reaching TIMEOUT_CYCLES, the watchdog SHALL force m_ena=0, set error, and go to FINISH.
REQ-031 req_nbytes of 0 SHALL be treated as 1; values >4 SHALL be clamped to 4.
REQ-032 Simultaneous requests SHALL be resolved only by the round-robin order; no fixed priority.

Reset
REQ-033 On reset_n low at a clock edge, the FSM SHALL go to IDLE.
REQ-034 On reset, outputs SHALL be: grant=0, done=0, data_rd=0, error=0, m_ena=0, m_addr=0, m_rw=0, m_data_wr=0, m_nbytes=0.
REQ-035 On reset, last_grant SHALL be NUM_REQ-1 and the watchdog 0.
REQ-036 Reset mid-transaction SHALL drop m_ena immediately and emit no done pulse.

Structure
REQ-037 A shared package SHALL hold the FSM state enum, the MAX_NBYTES=4 constant and the default TIMEOUT_CYCLES.
REQ-038 A single sub-module rr_select SHALL take req and last_grant and produce the one-hot next grant combinationally.
REQ-039 i2c_master SHALL be instantiated outside this block; the arbiter connects to it only through the m_* ports.

Verification
REQ-040 Single write: req[1]=1, addr 0x20, rw=0, nbytes 3, master model -> grant=0010, m_ena high until byte_counter=3, done[1] pulse, error=0.
REQ-041 Read: req[0] read, model returns 0x00ABC123 -> data_rd=0x00ABC123 in the done[0] cycle and held afterwards.
REQ-042 All four req held high -> grant order 0,1,2,3,0 with one done per grant and no overlapping m_ena.
REQ-043 Model asserts m_ack_error on byte 2 -> transaction completes, error=1 with done; next transaction shows error=0.
REQ-044 Model holds m_busy=1 forever, TIMEOUT_CYCLES=100 -> m_ena=0 and done with error=1 within 100 cycles of LOAD (+2).
REQ-045 reset_n low during XFER -> next cycle grant=0 and m_ena=0, no done pulse; a fresh req[2] is then served normally.
